// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding, parity constants and clog2 helper for the UART TX
package uart_pkg;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with full/empty/level; pushes while full are dropped
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [clog2(DEPTH):0]     level
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic push_ok, pop_ok;
  assign full  = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign dout  = mem_q[rd_q];
  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
    level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: FIFO-fed UART transmitter with prescaled bit timing, optional parity and 1/2 stop bits
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [DATA_WIDTH-1:0]        P_DATA,
  input  logic                         DATA_VALID,
  output logic                         READY,
  input  logic                         PAR_EN,
  input  logic                         PAR_TYP,
  input  logic                         STOP2,
  input  logic [PRESCALE_WIDTH-1:0]    PRESCALE,
  output logic                         TX_OUT,
  output logic                         Busy,
  output logic [clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);
  localparam int BW = clog2(DATA_WIDTH);
  logic [2:0] state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d, pre_q, pre_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, fifo_dout;
  logic par_en_q, par_en_d, stop2_q, stop2_d, par_bit_q, par_bit_d, tx_q, tx_d;
  logic fifo_full, fifo_empty, pop, tick;
  uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK), .rst(RST), .push(DATA_VALID), .pop(pop), .din(P_DATA),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .level(FIFO_LEVEL)
  );
  assign READY  = !fifo_full;
  assign Busy   = state_q != IDLE;
  assign TX_OUT = tx_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    pre_d     = pre_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    par_bit_d = par_bit_q;
    pop       = 1'b0;
    tick      = cnt_q == pre_q;
    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE:   pop = !fifo_empty;
      START:  if (tick) state_d = DATA;
      DATA: if (tick) begin
        sh_d  = sh_q >> 1;
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(DATA_WIDTH-1)) begin
          bit_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP: if (tick) begin
        if (stop2_q && bit_q == '0) bit_d = BW'(1);
        else begin
          bit_d   = '0;
          state_d = IDLE;
          pop     = !fifo_empty;
        end
      end
      default: state_d = IDLE;
    endcase
    // a pop always starts a new frame and snapshots the config for its whole duration
    if (pop) begin
      state_d   = START;
      cnt_d     = '0;
      sh_d      = fifo_dout;
      pre_d     = PRESCALE;
      par_en_d  = PAR_EN;
      stop2_d   = STOP2;
      par_bit_d = (PAR_TYP == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
    end
    tx_d = (state_q == START) ? 1'b0 : (state_q == DATA) ? sh_q[0] : (state_q == PARITY) ? par_bit_q : 1'b1;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      pre_q     <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      pre_q     <= pre_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: directed checks of framing, timing, FIFO handshake and reset for the UART TX
module tb_uart_tx_fifo_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] p_data = '0;
  logic data_valid = 1'b0;
  logic ready, par_en = 1'b0, par_typ = 1'b0, stop2 = 1'b0, tx_out, busy;
  logic [15:0] prescale = '0;
  logic [2:0] fifo_level;
  int total = 0, passed = 0, cyc = 0, busy_cycles = 0, base = 0;
  logic tx_log [0:4095];
  logic [7:0] words [6] = '{8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  uart_tx_fifo_param dut (
    .CLK(clk), .RST(rst), .P_DATA(p_data), .DATA_VALID(data_valid), .READY(ready),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
    .TX_OUT(tx_out), .Busy(busy), .FIFO_LEVEL(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 4096) tx_log[cyc] = tx_out;
    if (busy) busy_cycles++;
  endtask

  task automatic push(input logic [7:0] d);
    p_data = d;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  task automatic wait_low(input string tag, output int b);
    int k = 0;
    while (tx_out !== 1'b0 && k < 200) begin step(); k++; end
    chk(tag, 32'(k < 200), 1);
    b = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 500) begin step(); k++; end
    chk(tag, 32'(k < 500), 1);
  endtask

  task automatic check_log(input string tag, input int b, input logic [15:0] bits, input int n, input int per);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < per; j++)
        chk(tag, 32'(tx_log[b + i*per + j]), 32'(bits[i]));
  endtask

  initial begin
    repeat (2) step();
    chk("rst_tx", 32'(tx_out), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_level", 32'(fifo_level), 0);
    rst = 1'b0;
    step();
    // basic 8N1 frame at one clock per bit
    busy_cycles = 0;
    push(8'hA5);
    chk("t1_level_n", 32'(fifo_level), 1);
    chk("t1_busy_n", 32'(busy), 0);
    chk("t1_tx_n", 32'(tx_out), 1);
    step();
    chk("t1_busy_n1", 32'(busy), 1);
    chk("t1_level_n1", 32'(fifo_level), 0);
    chk("t1_tx_n1", 32'(tx_out), 1);
    step();
    chk("t1_tx_n2", 32'(tx_out), 0);
    base = cyc;
    wait_idle("t1_idle");
    chk("t1_busy_len", 32'(busy_cycles), 10);
    check_log("t1_frame", base, {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 1);
    // even and odd parity, prescale 3, two and one stop bits
    par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b1; prescale = 16'd3;
    push(8'h03);
    wait_low("t2_even_start", base);
    wait_idle("t2_even_idle");
    check_log("t2_even", base, {4'd0, 2'b11, 1'b0, 8'h03, 1'b0}, 12, 4);
    par_typ = 1'b1; stop2 = 1'b0;
    push(8'h03);
    wait_low("t2_odd_start", base);
    wait_idle("t2_odd_idle");
    check_log("t2_odd", base, {5'd0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 4);
    // back-to-back frames with FIFO filling, full-push-pop and a stalled source
    par_en = 1'b0; par_typ = 1'b0; prescale = 16'd0;
    busy_cycles = 0;
    push(words[0]);
    step();
    base = cyc + 1;
    data_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      p_data = words[i];
      step();
      if (i == 3) chk("t3_ready_at3", 32'(ready), 1);
    end
    chk("t3_ready_full", 32'(ready), 0);
    chk("t3_level_full", 32'(fifo_level), 4);
    p_data = words[5];
    begin
      int k = 0;
      while (ready !== 1'b1 && k < 100) begin step(); k++; end
      chk("t3_ready_wait", 32'(k < 100), 1);
    end
    chk("t6_full_pop_level", 32'(fifo_level), 3);
    step();
    data_valid = 1'b0;
    chk("t3_level_refill", 32'(fifo_level), 4);
    wait_idle("t3_idle");
    chk("t3_elapsed", 32'(cyc - base), 59);
    chk("t3_busy_len", 32'(busy_cycles), 60);
    for (int k = 0; k < 6; k++)
      check_log("t3_frames", base + 10*k, {6'd0, 1'b1, words[k], 1'b0}, 10, 1);
    // config change mid-frame only affects the next frame
    par_en = 1'b0; stop2 = 1'b0; prescale = 16'd1;
    push(8'h5A);
    push(8'hC3);
    wait_low("t4_start", base);
    repeat (3) step();
    par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1; prescale = 16'd0;
    wait_idle("t4_idle");
    check_log("t4_old_cfg", base, {6'd0, 1'b1, 8'h5A, 1'b0}, 10, 2);
    check_log("t4_new_cfg", base + 20, {4'd0, 2'b11, 1'b1, 8'hC3, 1'b0}, 12, 1);
    // reset during data bit 3 with two words queued
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 16'd3;
    push(8'hF0);
    push(8'h0F);
    push(8'hAA);
    wait_low("t5_start", base);
    repeat (17) step();
    chk("t5_tx_bit3", 32'(tx_out), 0);
    chk("t5_level_pre", 32'(fifo_level), 2);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx", 32'(tx_out), 1);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_level", 32'(fifo_level), 0);
    chk("t5_rst_ready", 32'(ready), 1);
    repeat (2) step();
    rst = 1'b0;
    busy_cycles = 0;
    repeat (40) step();
    chk("t5_no_frame_busy", 32'(busy_cycles), 0);
    chk("t5_no_frame_tx", 32'(tx_out), 1);
    chk("t5_level_post", 32'(fifo_level), 0);
    // push and pop in the same cycle at level 2
    prescale = 16'd0;
    push(8'h81);
    step();
    push(8'h82);
    push(8'h83);
    chk("t6_level2", 32'(fifo_level), 2);
    repeat (7) step();
    chk("t6_in_stop", 32'(busy), 1);
    push(8'h84);
    chk("t6_pushpop_level", 32'(fifo_level), 2);
    chk("t6_pushpop_ready", 32'(ready), 1);
    chk("t6_pushpop_busy", 32'(busy), 1);
    wait_idle("t6_idle");
    chk("t6_final_level", 32'(fifo_level), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
